// File: rtl/mask_rev_scanner_if.sv
// -----------------------------------------------------------------------------
// mask_rev_scanner_if
//   Bundles the control inputs and the display/serial outputs of
//   mask_rev_scanner. clk and rst are plain ports on the module and are not
//   part of this interface.
//
//   master : drives ena, mask_rev, mode, index, dwell, ser_start;
//            observes seg_out, dp, digit_idx, ser_data, ser_valid, ser_busy
//   slave  : the scanner itself (opposite directions)
//
//   Serial handshake: ser_valid marks each bit of ser_data. There is no
//   ready/backpressure, so the consumer must take a bit on every cycle that
//   ser_valid is high. ser_busy covers the whole word.
// -----------------------------------------------------------------------------
interface mask_rev_scanner_if #(
  parameter int REV_WIDTH = 32,
  parameter int DIV_W     = 16
);
  localparam int NIBBLES = REV_WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);

  logic                 ena;
  logic [REV_WIDTH-1:0] mask_rev;
  logic [1:0]           mode;
  logic [IDX_W-1:0]     index;
  logic [DIV_W-1:0]     dwell;
  logic                 ser_start;

  logic [6:0]           seg_out;
  logic                 dp;
  logic [IDX_W-1:0]     digit_idx;
  logic                 ser_data;
  logic                 ser_valid;
  logic                 ser_busy;

  modport master (
    output ena, mask_rev, mode, index, dwell, ser_start,
    input  seg_out, dp, digit_idx, ser_data, ser_valid, ser_busy
  );

  modport slave (
    input  ena, mask_rev, mode, index, dwell, ser_start,
    output seg_out, dp, digit_idx, ser_data, ser_valid, ser_busy
  );
endinterface

// File: rtl/mask_rev_scanner.sv
// -----------------------------------------------------------------------------
// mask_rev_scanner
//   Captures a REV_WIDTH-bit mask revision word and shows it on one 7-segment
//   digit: manual nibble select (mode 00/11), auto-scan with programmable
//   dwell (mode 01), or MSB-first bit-serial shift-out on a start strobe
//   (mode 10).
//
//   clk          system clock
//   rst          asynchronous active-high reset
//   bus          mask_rev_scanner_if.slave (controls, display and serial outs)
//   o_dbg_state  serial FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module mask_rev_scanner #(
  parameter int REV_WIDTH = 32,
  parameter int DIV_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mask_rev_scanner_if.slave     bus,
  output logic [1:0]            o_dbg_state
);
  localparam int NIBBLES = REV_WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam int BIT_W   = $clog2(REV_WIDTH);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W:0]   NIB_EXT  = (IDX_W + 1)'(NIBBLES);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(REV_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  state_t               r_state;
  logic [BIT_W-1:0]     r_bitcnt;
  logic [REV_WIDTH-1:0] r_snap;
  logic [DIV_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [6:0]           r_seg;
  logic                 r_dp;
  logic [1:0]           r_mode_q;

  state_t               w_state_nxt;
  logic [BIT_W-1:0]     w_bitcnt_nxt;
  logic [REV_WIDTH-1:0] w_snap_nxt;
  logic [DIV_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_dp_nxt;
  logic [BIT_W-1:0]     w_pos_nxt;
  logic [BIT_W-1:0]     w_pos;
  logic [3:0]           w_nib;
  logic                 w_blank;
  logic [6:0]           w_seg_nxt;
  logic                 w_auto;
  logic                 w_ser;
  logic                 w_auto_q;

  assign w_auto   = (bus.mode == 2'b01);
  assign w_ser    = (bus.mode == 2'b10);
  assign w_auto_q = (r_mode_q == 2'b01);

  // Bit currently presented while shifting (MSB first).
  assign w_pos = BIT_LAST - r_bitcnt;

  // Next-state / next-datapath. The display registers are loaded from the
  // *next* snapshot and index so seg_out always matches digit_idx.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_snap_nxt   = r_snap;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_dp_nxt     = 1'b0;
    w_pos_nxt    = BIT_LAST - r_bitcnt;

    // Serial FSM: only starts in serial mode; leaving serial mode aborts.
    case (r_state)
      S_IDLE: begin
        if (w_ser && bus.ser_start) begin
          w_state_nxt  = S_SHIFT;
          w_bitcnt_nxt = '0;
          w_snap_nxt   = bus.mask_rev;
        end
      end
      S_SHIFT: begin
        if (!w_ser) begin
          w_state_nxt = S_IDLE;
        end else if (r_bitcnt == BIT_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_bitcnt_nxt = r_bitcnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_pos_nxt = BIT_LAST - w_bitcnt_nxt;

    if (w_auto) begin
      if (!w_auto_q) begin
        // Fresh entry into auto-scan restarts the sweep on a new snapshot.
        w_idx_nxt  = '0;
        w_cnt_nxt  = '0;
        w_snap_nxt = bus.mask_rev;
      end else if (r_cnt >= bus.dwell) begin
        // >= so that lowering dwell below the running count still advances.
        w_cnt_nxt = '0;
        if (r_idx == IDX_LAST) begin
          w_idx_nxt  = '0;
          w_snap_nxt = bus.mask_rev;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      w_dp_nxt = (w_idx_nxt == '0);
    end else if (w_ser) begin
      if (w_state_nxt == S_SHIFT) begin
        w_idx_nxt = IDX_W'(w_pos_nxt >> 2);
      end else begin
        w_idx_nxt = IDX_LAST;
      end
    end else begin
      w_snap_nxt = bus.mask_rev;
      w_idx_nxt  = bus.index;
    end
  end

  assign w_nib     = w_snap_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign w_blank   = ({1'b0, w_idx_nxt} >= NIB_EXT);
  assign w_seg_nxt = w_blank ? 7'h00 : hex7(w_nib);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_snap   <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_seg    <= '0;
      r_dp     <= 1'b0;
      r_mode_q <= 2'b00;
    end else if (bus.ena) begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_snap   <= w_snap_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_seg    <= w_seg_nxt;
      r_dp     <= w_dp_nxt;
      r_mode_q <= bus.mode;
    end
  end

  assign bus.seg_out   = r_seg;
  assign bus.dp        = r_dp;
  assign bus.digit_idx = r_idx;
  assign bus.ser_valid = (r_state == S_SHIFT);
  assign bus.ser_busy  = (r_state == S_SHIFT);
  assign bus.ser_data  = (r_state == S_SHIFT) ? r_snap[w_pos] : 1'b0;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_mask_rev_scanner.sv
// -----------------------------------------------------------------------------
// tb_mask_rev_scanner
//   Directed bench for mask_rev_scanner: a 32-bit instance for reset, manual,
//   auto-scan, enable, serial and abort scenarios, and an 8-bit instance for
//   the narrow auto-scan case.
// -----------------------------------------------------------------------------
module tb_mask_rev_scanner;
  logic clk;
  logic rst;
  logic [1:0] dbg32;
  logic [1:0] dbg8;

  int n_checks;
  int n_pass;

  mask_rev_scanner_if #(.REV_WIDTH(32), .DIV_W(16)) bus32 ();
  mask_rev_scanner_if #(.REV_WIDTH(8),  .DIV_W(16)) bus8 ();

  mask_rev_scanner #(.REV_WIDTH(32), .DIV_W(16)) u_dut32 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus32),
    .o_dbg_state (dbg32)
  );

  mask_rev_scanner #(.REV_WIDTH(8), .DIV_W(16)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus8),
    .o_dbg_state (dbg8)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected segment pattern for one hex digit.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  function automatic logic [3:0] nib_of(input logic [31:0] w, input int idx);
    return 4'(w >> (4 * idx));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus32.ena = 1'b1; bus32.mode = 2'b01; bus32.dwell = 16'd2;
    bus32.mask_rev = 32'h1234ABCD;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus32.seg_out !== 7'h00) $display("FAIL reset_seg got %h exp 00", bus32.seg_out);
    else n_pass++;
    n_checks++;
    if (bus32.dp !== 1'b0) $display("FAIL reset_dp got %b exp 0", bus32.dp);
    else n_pass++;
    n_checks++;
    if (bus32.digit_idx !== 3'd0) $display("FAIL reset_idx got %0d exp 0", bus32.digit_idx);
    else n_pass++;
    n_checks++;
    if ({bus32.ser_data, bus32.ser_valid, bus32.ser_busy} !== 3'b000)
      $display("FAIL reset_ser got %b exp 000", {bus32.ser_data, bus32.ser_valid, bus32.ser_busy});
    else n_pass++;
    n_checks++;
    if (dbg32 !== 2'd0) $display("FAIL reset_state got %0d exp 0", dbg32);
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus32.digit_idx !== 3'd0) $display("FAIL post_reset_idx got %0d exp 0", bus32.digit_idx);
    else n_pass++;
    n_checks++;
    if (bus32.seg_out !== 7'h5E) $display("FAIL post_reset_seg got %h exp 5e", bus32.seg_out);
    else n_pass++;
  endtask

  task automatic test_manual();
    logic [2:0] idx_tab [4];
    logic [6:0] exp_tab [4];
    idx_tab = '{3'd0, 3'd7, 3'd3, 3'd4};
    exp_tab = '{7'h5E, 7'h06, 7'h77, 7'h66};
    bus32.mode = 2'b00;
    bus32.mask_rev = 32'h1234ABCD;
    for (int k = 0; k < 4; k++) begin
      bus32.index = idx_tab[k];
      tick();
      n_checks++;
      if (bus32.seg_out !== exp_tab[k])
        $display("FAIL manual_seg idx %0d got %h exp %h", idx_tab[k], bus32.seg_out, exp_tab[k]);
      else n_pass++;
      n_checks++;
      if (bus32.digit_idx !== idx_tab[k] || bus32.dp !== 1'b0)
        $display("FAIL manual_idx got %0d/%b exp %0d/0", bus32.digit_idx, bus32.dp, idx_tab[k]);
      else n_pass++;
    end
  endtask

  task automatic test_auto_scan();
    logic [31:0] word;
    int          e_idx;
    bus32.mode = 2'b00;
    bus32.mask_rev = 32'h1234ABCD;
    tick();
    bus32.mode = 2'b01;
    bus32.dwell = 16'd2;
    tick();
    for (int s = 0; s < 27; s++) begin
      e_idx = (s / 3) % 8;
      word  = (s >= 24) ? 32'hFFFFFFFF : 32'h1234ABCD;
      n_checks++;
      if (bus32.digit_idx !== 3'(e_idx))
        $display("FAIL auto_idx step %0d got %0d exp %0d", s, bus32.digit_idx, e_idx);
      else n_pass++;
      n_checks++;
      if (bus32.seg_out !== seg_of(nib_of(word, e_idx)))
        $display("FAIL auto_seg step %0d got %h exp %h", s, bus32.seg_out, seg_of(nib_of(word, e_idx)));
      else n_pass++;
      n_checks++;
      if (bus32.dp !== (e_idx == 0))
        $display("FAIL auto_dp step %0d got %b exp %b", s, bus32.dp, (e_idx == 0));
      else n_pass++;
      if (s == 10) bus32.mask_rev = 32'hFFFFFFFF;
      tick();
    end
  endtask

  task automatic test_enable();
    bus32.mode = 2'b00;
    bus32.mask_rev = 32'h1234ABCD;
    tick();
    bus32.mode = 2'b01;
    bus32.dwell = 16'd0;
    tick();
    tick();
    bus32.ena = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus32.digit_idx !== 3'd1 || bus32.seg_out !== 7'h39)
      $display("FAIL ena_hold got %0d/%h exp 1/39", bus32.digit_idx, bus32.seg_out);
    else n_pass++;
    bus32.ena = 1'b1;
    tick();
    n_checks++;
    if (bus32.digit_idx !== 3'd2 || bus32.seg_out !== 7'h7C)
      $display("FAIL ena_resume got %0d/%h exp 2/7c", bus32.digit_idx, bus32.seg_out);
    else n_pass++;
  endtask

  task automatic test_serial();
    logic [31:0] word;
    int          pos;
    word = 32'hA5000001;
    bus32.mode = 2'b10;
    bus32.mask_rev = word;
    tick();
    bus32.ser_start = 1'b1;
    tick();
    bus32.ser_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pos = 31 - i;
      n_checks++;
      if (bus32.ser_valid !== 1'b1 || bus32.ser_busy !== 1'b1 || bus32.ser_data !== word[pos])
        $display("FAIL serial_bit %0d got v%b b%b d%b exp v1 b1 d%b",
                 i, bus32.ser_valid, bus32.ser_busy, bus32.ser_data, word[pos]);
      else n_pass++;
      n_checks++;
      if (bus32.digit_idx !== 3'(pos / 4) || bus32.seg_out !== seg_of(nib_of(word, pos / 4)))
        $display("FAIL serial_seg %0d got %0d/%h exp %0d/%h", i, bus32.digit_idx,
                 bus32.seg_out, pos / 4, seg_of(nib_of(word, pos / 4)));
      else n_pass++;
      bus32.ser_start = (i == 5);
      tick();
    end
    bus32.ser_start = 1'b0;
    n_checks++;
    if (bus32.ser_valid !== 1'b0 || bus32.ser_busy !== 1'b0 || dbg32 !== 2'd2)
      $display("FAIL serial_done got v%b b%b st%0d exp v0 b0 st2",
               bus32.ser_valid, bus32.ser_busy, dbg32);
    else n_pass++;
    n_checks++;
    if (bus32.digit_idx !== 3'd7 || bus32.seg_out !== 7'h77)
      $display("FAIL serial_idle_seg got %0d/%h exp 7/77", bus32.digit_idx, bus32.seg_out);
    else n_pass++;
    tick();
    n_checks++;
    if (bus32.ser_busy !== 1'b0 || dbg32 !== 2'd0)
      $display("FAIL serial_idle got b%b st%0d exp b0 st0", bus32.ser_busy, dbg32);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [31:0] word;
    word = 32'hA5000001;
    bus32.mode = 2'b10;
    bus32.mask_rev = word;
    bus32.ser_start = 1'b1;
    tick();
    bus32.ser_start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      n_checks++;
      if (bus32.ser_valid !== 1'b1 || bus32.ser_data !== word[31 - i])
        $display("FAIL abort_pre_bit %0d got v%b d%b exp v1 d%b",
                 i, bus32.ser_valid, bus32.ser_data, word[31 - i]);
      else n_pass++;
      if (i != 10) tick();
    end
    bus32.mode = 2'b00;
    tick();
    n_checks++;
    if ({bus32.ser_data, bus32.ser_valid, bus32.ser_busy} !== 3'b000)
      $display("FAIL abort_drop got %b exp 000", {bus32.ser_data, bus32.ser_valid, bus32.ser_busy});
    else n_pass++;
    bus32.mode = 2'b10;
    tick();
    bus32.ser_start = 1'b1;
    tick();
    bus32.ser_start = 1'b0;
    n_checks++;
    if (bus32.ser_valid !== 1'b1 || bus32.ser_data !== 1'b1 || bus32.digit_idx !== 3'd7)
      $display("FAIL abort_restart_msb got v%b d%b i%0d exp v1 d1 i7",
               bus32.ser_valid, bus32.ser_data, bus32.digit_idx);
    else n_pass++;
    tick();
    n_checks++;
    if (bus32.ser_valid !== 1'b1 || bus32.ser_data !== 1'b0)
      $display("FAIL abort_restart_bit30 got v%b d%b exp v1 d0", bus32.ser_valid, bus32.ser_data);
    else n_pass++;
    bus32.mode = 2'b00;
    tick();
  endtask

  task automatic test_width8();
    logic [6:0] e_seg;
    bus8.mode = 2'b00;
    bus8.mask_rev = 8'h3C;
    tick();
    bus8.mode = 2'b01;
    bus8.dwell = 16'd0;
    tick();
    for (int s = 0; s < 6; s++) begin
      e_seg = (s % 2 == 0) ? 7'h39 : 7'h4F;
      n_checks++;
      if (bus8.seg_out !== e_seg || bus8.digit_idx !== 1'(s % 2) || bus8.dp !== (s % 2 == 0))
        $display("FAIL w8_scan step %0d got %h/%0d/%b exp %h/%0d/%b", s, bus8.seg_out,
                 bus8.digit_idx, bus8.dp, e_seg, s % 2, (s % 2 == 0));
      else n_pass++;
      tick();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus32.ena = 1'b1; bus32.mask_rev = '0; bus32.mode = 2'b00;
    bus32.index = '0; bus32.dwell = '0; bus32.ser_start = 1'b0;
    bus8.ena = 1'b1; bus8.mask_rev = '0; bus8.mode = 2'b00;
    bus8.index = '0; bus8.dwell = '0; bus8.ser_start = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    test_reset();
    test_manual();
    test_auto_scan();
    test_enable();
    test_serial();
    test_abort();
    test_width8();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
